// File: rtl/byp_hzd_ctrl_pkg.sv
// Shared constants and types for the ID-stage forwarding/hazard controller.
// Optional build macro: BYP_HZD_R0_ZERO_EN (register 0 is hard-wired zero).
`timescale 1ns/1ps
package byp_hzd_ctrl_pkg;

   localparam int REG_AW_DEF = 5;
   localparam int ZERO_REG   = 0;

   // Write/load status that travels with a destination register down the pipe.
   typedef struct packed {
      logic we;
      logic ld;
   } trk_flags_t;

   localparam trk_flags_t TRK_BUBBLE = '{we: 1'b0, ld: 1'b0};

endpackage

// File: rtl/byp_hzd_ctrl_port_cmp.sv
// Per-port comparator: EX/DM bypass next-state and the load-use term for one RF read port.
// Optional build macro: BYP_HZD_R0_ZERO_EN (compares against register 0 are forced false).
`timescale 1ns/1ps
module byp_port_cmp
   import byp_hzd_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] src_addr,
   input  logic              re,
   input  logic [REG_AW-1:0] dst_id_ex,
   input  logic              we_id_ex,
   input  logic              ld_id_ex,
   input  logic [REG_AW-1:0] dst_ex_dm,
   input  logic              we_ex_dm,
   output logic              byp_ex_nxt,
   output logic              byp_dm_nxt,
   output logic              lu_term
);

   logic hit_id_ex;
   logic hit_ex_dm;
   logic src_valid;

`ifdef BYP_HZD_R0_ZERO_EN
   // Register 0 always reads as zero, so it can never be a forwarding target.
   assign src_valid = re & (src_addr != REG_AW'(ZERO_REG));
`else
   assign src_valid = re;
`endif

   assign hit_id_ex = src_valid & (src_addr == dst_id_ex);
   assign hit_ex_dm = src_valid & (src_addr == dst_ex_dm);

   // A load in ID_EX has no result to forward yet; it becomes a stall instead.
   assign byp_ex_nxt = hit_id_ex & we_id_ex & ~ld_id_ex;
   assign byp_dm_nxt = hit_ex_dm & we_ex_dm;
   assign lu_term    = hit_id_ex & we_id_ex & ld_id_ex;

endmodule

// File: rtl/byp_hzd_ctrl.sv
// ID-stage forwarding and load-use hazard controller for the 5-stage core.
// Optional build macro: BYP_HZD_R0_ZERO_EN (register 0 never bypasses or stalls).
`timescale 1ns/1ps
module byp_hzd_ctrl
   import byp_hzd_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] src0_addr_ID,
   input  logic [REG_AW-1:0] src1_addr_ID,
   input  logic              re0_ID,
   input  logic              re1_ID,
   input  logic [REG_AW-1:0] dst_addr_ID,
   input  logic              we_ID,
   input  logic              ld_ID,
   input  logic              stall_pipe,
   input  logic              flush_ID_EX,
   output logic              byp0_EX,
   output logic              byp0_DM,
   output logic              byp1_EX,
   output logic              byp1_DM,
   output logic              load_use_stall
);

   logic [REG_AW-1:0] dst_id_ex;
   logic [REG_AW-1:0] dst_ex_dm;
   trk_flags_t        flg_id_ex;
   logic              we_ex_dm;

   logic byp0_ex_nxt;
   logic byp0_dm_nxt;
   logic byp1_ex_nxt;
   logic byp1_dm_nxt;
   logic lu0;
   logic lu1;
   logic bubble;

   byp_port_cmp #(.REG_AW(REG_AW)) u_cmp0 (
      .src_addr   (src0_addr_ID),
      .re         (re0_ID),
      .dst_id_ex  (dst_id_ex),
      .we_id_ex   (flg_id_ex.we),
      .ld_id_ex   (flg_id_ex.ld),
      .dst_ex_dm  (dst_ex_dm),
      .we_ex_dm   (we_ex_dm),
      .byp_ex_nxt (byp0_ex_nxt),
      .byp_dm_nxt (byp0_dm_nxt),
      .lu_term    (lu0)
   );

   byp_port_cmp #(.REG_AW(REG_AW)) u_cmp1 (
      .src_addr   (src1_addr_ID),
      .re         (re1_ID),
      .dst_id_ex  (dst_id_ex),
      .we_id_ex   (flg_id_ex.we),
      .ld_id_ex   (flg_id_ex.ld),
      .dst_ex_dm  (dst_ex_dm),
      .we_ex_dm   (we_ex_dm),
      .byp_ex_nxt (byp1_ex_nxt),
      .byp_dm_nxt (byp1_dm_nxt),
      .lu_term    (lu1)
   );

   assign load_use_stall = lu0 | lu1;
   // A flush coinciding with a load-use still inserts only one bubble.
   assign bubble         = flush_ID_EX | load_use_stall;

   // EX_DM tracking always advances from ID_EX unless the whole pipe is frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dst_ex_dm <= '0;
         we_ex_dm  <= 1'b0;
      end else if (!stall_pipe) begin
         dst_ex_dm <= dst_id_ex;
         we_ex_dm  <= flg_id_ex.we;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dst_id_ex <= '0;
         flg_id_ex <= TRK_BUBBLE;
      end else if (!stall_pipe) begin
         if (bubble) begin
            dst_id_ex <= '0;
            flg_id_ex <= TRK_BUBBLE;
         end else begin
            dst_id_ex <= dst_addr_ID;
            flg_id_ex <= '{we: we_ID, ld: ld_ID};
         end
      end
   end

   // Bypass flags are flopped alongside the RF read data so they line up in EX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byp0_EX <= 1'b0;
         byp0_DM <= 1'b0;
         byp1_EX <= 1'b0;
         byp1_DM <= 1'b0;
      end else if (!stall_pipe) begin
         if (bubble) begin
            byp0_EX <= 1'b0;
            byp0_DM <= 1'b0;
            byp1_EX <= 1'b0;
            byp1_DM <= 1'b0;
         end else begin
            byp0_EX <= byp0_ex_nxt;
            byp0_DM <= byp0_dm_nxt;
            byp1_EX <= byp1_ex_nxt;
            byp1_DM <= byp1_dm_nxt;
         end
      end
   end

endmodule

// File: tb/tb_byp_hzd_ctrl.sv
// Self-checking bench for byp_hzd_ctrl: instruction-level reference model plus directed literal checks.
// Honours BYP_HZD_R0_ZERO_EN when the same macro is defined for the build.
`timescale 1ns/1ps
module tb_byp_hzd_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] src0_addr_ID = '0;
   logic [4:0] src1_addr_ID = '0;
   logic       re0_ID = 1'b0;
   logic       re1_ID = 1'b0;
   logic [4:0] dst_addr_ID = '0;
   logic       we_ID = 1'b0;
   logic       ld_ID = 1'b0;
   logic       stall_pipe = 1'b0;
   logic       flush_ID_EX = 1'b0;
   logic       byp0_EX;
   logic       byp0_DM;
   logic       byp1_EX;
   logic       byp1_DM;
   logic       load_use_stall;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   byp_hzd_ctrl #(.REG_AW(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .src0_addr_ID   (src0_addr_ID),
      .src1_addr_ID   (src1_addr_ID),
      .re0_ID         (re0_ID),
      .re1_ID         (re1_ID),
      .dst_addr_ID    (dst_addr_ID),
      .we_ID          (we_ID),
      .ld_ID          (ld_ID),
      .stall_pipe     (stall_pipe),
      .flush_ID_EX    (flush_ID_EX),
      .byp0_EX        (byp0_EX),
      .byp0_DM        (byp0_DM),
      .byp1_EX        (byp1_EX),
      .byp1_DM        (byp1_DM),
      .load_use_stall (load_use_stall)
   );

   always #5 clk = ~clk;

   // Reference model: the instructions sitting in EX and DM, and which operands need forwarding.
   typedef struct packed {
      logic [4:0] dst;
      logic       we;
      logic       ld;
   } instr_t;

   instr_t in_ex;
   instr_t in_dm;
   logic   m_b0ex, m_b0dm, m_b1ex, m_b1dm;

   function automatic logic same_reg(input logic [4:0] a, input logic [4:0] b);
`ifdef BYP_HZD_R0_ZERO_EN
      return (a == b) && (a != 5'd0);
`else
      return a == b;
`endif
   endfunction

   function automatic logic wants_from(input logic re, input logic [4:0] src, input instr_t producer);
      return re && producer.we && same_reg(src, producer.dst);
   endfunction

   function automatic logic model_stall();
      return in_ex.ld && (wants_from(re0_ID, src0_addr_ID, in_ex) || wants_from(re1_ID, src1_addr_ID, in_ex));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ex  <= '0;
         in_dm  <= '0;
         m_b0ex <= 1'b0;
         m_b0dm <= 1'b0;
         m_b1ex <= 1'b0;
         m_b1dm <= 1'b0;
      end else if (!stall_pipe) begin
         in_dm <= in_ex;
         if (flush_ID_EX || model_stall()) begin
            in_ex  <= '0;
            m_b0ex <= 1'b0;
            m_b0dm <= 1'b0;
            m_b1ex <= 1'b0;
            m_b1dm <= 1'b0;
         end else begin
            in_ex  <= '{dst: dst_addr_ID, we: we_ID, ld: ld_ID};
            m_b0ex <= wants_from(re0_ID, src0_addr_ID, in_ex) && !in_ex.ld;
            m_b0dm <= wants_from(re0_ID, src0_addr_ID, in_dm);
            m_b1ex <= wants_from(re1_ID, src1_addr_ID, in_ex) && !in_ex.ld;
            m_b1dm <= wants_from(re1_ID, src1_addr_ID, in_dm);
         end
      end
   end

   task automatic checkOutput(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0b expected=%0b at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         checkOutput("model_byp0_EX", byp0_EX, m_b0ex);
         checkOutput("model_byp0_DM", byp0_DM, m_b0dm);
         checkOutput("model_byp1_EX", byp1_EX, m_b1ex);
         checkOutput("model_byp1_DM", byp1_DM, m_b1dm);
         checkOutput("model_load_use_stall", load_use_stall, model_stall());
      end
   end

   // Present one instruction in ID for the coming cycle.
   task automatic applyStimulus(input logic [4:0] s0, input logic [4:0] s1, input logic r0, input logic r1,
                                input logic [4:0] d, input logic w, input logic l,
                                input logic st, input logic fl);
      @(posedge clk);
      #1;
      src0_addr_ID = s0;
      src1_addr_ID = s1;
      re0_ID       = r0;
      re1_ID       = r1;
      dst_addr_ID  = d;
      we_ID        = w;
      ld_ID        = l;
      stall_pipe   = st;
      flush_ID_EX  = fl;
   endtask

   task automatic nop();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkLiteral(input string name, input logic b0e, input logic b0d,
                               input logic b1e, input logic b1d, input logic lu);
      @(negedge clk);
      checkOutput({name, "_byp0_EX"}, byp0_EX, b0e);
      checkOutput({name, "_byp0_DM"}, byp0_DM, b0d);
      checkOutput({name, "_byp1_EX"}, byp1_EX, b1e);
      checkOutput({name, "_byp1_DM"}, byp1_DM, b1d);
      checkOutput({name, "_lu"}, load_use_stall, lu);
   endtask

   logic r0_exp;

   initial begin
`ifdef BYP_HZD_R0_ZERO_EN
      r0_exp = 1'b0;
`else
      r0_exp = 1'b1;
`endif
      #2;
      checkLiteral("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      nop();

      // EX-distance forward on src0
      applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      nop();
      checkLiteral("ex_fwd", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // DM-distance forward on src1
      applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'd8, 5'd9, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'd10, 5'd3, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
      nop();
      checkLiteral("dm_fwd", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Load-use: one stall cycle, bubble, then DM forward on replay
      applyStimulus(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      checkLiteral("lu_stall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      checkLiteral("lu_bubble", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      nop();
      checkLiteral("lu_replay", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Unused port never stalls or bypasses
      applyStimulus(5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(5'd6, 5'd6, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      checkLiteral("re0_off_lu", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      nop();
      checkLiteral("re0_off_byp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Register 0 producer/consumer
      applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'd0, 5'd1, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
      nop();
      checkLiteral("r0", r0_exp, 1'b0, 1'b0, 1'b0, 1'b0);

      // Global freeze holds the bypass flags
      applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         checkLiteral("stall_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      nop();
      checkLiteral("stall_release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Flush overlapping a load-use: a single bubble
      applyStimulus(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
      checkLiteral("flush_lu", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      checkLiteral("flush_bubble", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      nop();
      checkLiteral("flush_after", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Async reset mid-stream while byp1_DM is set
      applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'd8, 5'd9, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'd10, 5'd4, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
      nop();
      checkLiteral("pre_reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({byp0_EX, byp0_DM, byp1_EX, byp1_DM, load_use_stall} !== 5'b0) begin
         failures++;
         $display("[TB] FAIL async_reset actual=%05b expected=00000", {byp0_EX, byp0_DM, byp1_EX, byp1_DM, load_use_stall});
      end
      nop();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(5'd4, 5'd4, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
      nop();
      checkLiteral("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      nop();
      nop();
      @(negedge clk);
      cmp_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
